// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: MDU sequencer states,
// default multiply/divide latencies and the stall counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam int CNT_W        = 6;
  localparam int DEF_MULT_LAT = 4;
  localparam int DEF_DIV_LAT  = 33;

  // Counter preload: the accept cycle itself is the first stall cycle.
  function automatic logic [CNT_W-1:0] lat_preload(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: flags an ID-stage source operand that matches the
// destination of a load still sitting in EX.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_is_load,
  input  logic       ex_RF_W_ena,
  input  logic [4:0] ex_RF_waddr,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used & (id_rs == ex_RF_waddr);
  assign rt_hit = id_rt_used & (id_rt == ex_RF_waddr);

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load & ex_RF_W_ena & (ex_RF_waddr != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Five-stage pipeline stall/flush controller: arbitrates DMEM wait, multi-cycle
// MDU stalls, load-use bubbles and ID-resolved jump flushes.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_is_load,
  input  logic             ex_RF_W_ena,
  input  logic [4:0]       ex_RF_waddr,
  input  logic             ex_mdu_start,
  input  logic             ex_mdu_div,
  input  logic             id_jump_taken,
  input  logic             mem_wait,
  output logic             pc_W_ena,
  output logic             IR_W_ena,
  output logic             DE_W_ena,
  output logic             EM_W_ena,
  output logic             MW_W_ena,
  output logic             IR_flush,
  output logic             DE_flush,
  output logic             EM_flush,
  output logic             mdu_busy,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;
  logic             accept;
  logic             mdu_stall;

  pipe_hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .ex_is_load  (ex_is_load),
    .ex_RF_W_ena (ex_RF_W_ena),
    .ex_RF_waddr (ex_RF_waddr),
    .load_use    (load_use)
  );

  assign accept    = (state == IDLE) & ex_mdu_start & ~mem_wait;
  assign mdu_stall = accept | (state == MDU_BUSY);
  assign mdu_busy  = mdu_stall;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The MDU keeps computing while DMEM stalls, so the countdown ignores mem_wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = ex_mdu_div ? lat_preload(DIV_LAT) : lat_preload(MULT_LAT);
          state_next = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_next = MDU_DONE;
      end
      MDU_DONE: begin
        if (!mem_wait) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A stage register loads when its W_ena is high; a flush with W_ena loads a bubble.
  // Priority: mem_wait > MDU stall > load-use > jump flush.
  always_comb begin
    pc_W_ena = 1'b1;
    IR_W_ena = 1'b1;
    DE_W_ena = 1'b1;
    EM_W_ena = 1'b1;
    MW_W_ena = 1'b1;
    IR_flush = 1'b0;
    DE_flush = 1'b0;
    EM_flush = 1'b0;
    if (mem_wait) begin
      pc_W_ena = 1'b0;
      IR_W_ena = 1'b0;
      DE_W_ena = 1'b0;
      EM_W_ena = 1'b0;
      MW_W_ena = 1'b0;
    end else if (mdu_stall) begin
      pc_W_ena = 1'b0;
      IR_W_ena = 1'b0;
      DE_W_ena = 1'b0;
      EM_flush = 1'b1;
    end else if (load_use) begin
      pc_W_ena = 1'b0;
      IR_W_ena = 1'b0;
      DE_flush = 1'b1;
    end else if (id_jump_taken) begin
      IR_flush = 1'b1;
    end
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4: total stall cycles for a multiply; legal range 2..63.
REQ-002 SHALL have parameter DIV_LAT, default 33: total stall cycles for a divide; legal range 2..63.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have inputs: id_rs  input  5  ID source reg; id_rt  input  5  ID second source; id_rs_used  input  1; id_rt_used  input  1.
REQ-005 SHALL have inputs: ex_is_load  input  1  load in EX; ex_RF_W_ena  input  1  EX writes RF; ex_RF_waddr  input  5  EX dest reg.
REQ-006 SHALL have inputs: ex_mdu_start  input  1  mult/div in EX; ex_mdu_div  input  1  1=div, 0=mult; id_jump_taken  input  1  redirect resolved in ID; mem_wait  input  1  DMEM not ready.
REQ-007 SHALL have outputs, each 1 bit: pc_W_ena, IR_W_ena (IF/ID), DE_W_ena (ID/EX), EM_W_ena (EX/MEM), MW_W_ena (MEM/WB) as register enables; IR_flush, DE_flush, EM_flush as load-zero-when-enabled requests; mdu_busy.

Function
REQ-008 SHALL implement states IDLE, MDU_BUSY, MDU_DONE plus a 6-bit down-counter cnt.
REQ-009 SHALL define load_use = ex_is_load & ex_RF_W_ena & (ex_RF_waddr != 0) & ((id_rs_used & id_rs == ex_RF_waddr) | (id_rt_used & id_rt == ex_RF_waddr)).
REQ-010 SHALL define accept = (state == IDLE) & ex_mdu_start & ~mem_wait.
REQ-011 SHALL apply priority: mem_wait > MDU stall (accept or MDU_BUSY) > load_use > id_jump_taken.
REQ-012 SHALL, when mem_wait=1, drive all five W_ena and all flushes to 0, regardless of state.
REQ-013 SHALL, on accept or in MDU_BUSY without mem_wait, drive pc/IR/DE_W_ena=0, EM_W_ena=1, EM_flush=1, MW_W_ena=1.
REQ-014 SHALL, on load_use in IDLE/MDU_DONE without higher priority, drive pc_W_ena=IR_W_ena=0, DE_W_ena=1, DE_flush=1, EM/MW_W_ena=1.
REQ-015 SHALL, on id_jump_taken without higher-priority condition, drive IR_flush=1 with all W_ena=1; a jump coinciding with load_use SHALL NOT flush.
REQ-016 SHALL otherwise drive all W_ena=1 and all flushes 0; all outputs are combinational from state and inputs.
REQ-017 SHALL on accept load cnt with (ex_mdu_div ? DIV_LAT : MULT_LAT) - 1 and enter MDU_BUSY.
REQ-018 SHALL in MDU_BUSY decrement cnt every cycle, including while mem_wait=1; at cnt==1 go to MDU_DONE.
REQ-019 SHALL in MDU_DONE ignore ex_mdu_start, stay while mem_wait=1, and go to IDLE on the first cycle with mem_wait=0.
REQ-020 SHALL give total stall cycles (EM_flush high, mem_wait low) = selected latency.
REQ-021 SHALL drive mdu_busy = accept | (state == MDU_BUSY).

Reset
REQ-022 SHALL on rst=1 at a clk edge set state=IDLE and cnt=0, aborting any MDU stall.
REQ-023 SHALL, in the cycle after reset with idle inputs, drive all W_ena=1, all flushes 0 and mdu_busy=0.

Structure
REQ-024 SHALL place state encodings (IDLE=0, MDU_BUSY=1, MDU_DONE=2) and default latencies in shared package pipe_ctrl_pkg.
REQ-025 SHALL isolate the load_use comparator in combinational sub-module pipe_hazard_detect.

Verification
REQ-026 Load-use: ex_is_load=1, ex_RF_waddr=5, id_rs=5, id_rs_used=1 -> one cycle pc/IR_W_ena=0, DE_flush=1; next cycle all enables 1.
REQ-027 Zero register: same as REQ-026 with ex_RF_waddr=0 -> no stall.
REQ-028 Multiply: ex_mdu_start=1, div=0 held at cycle 0 -> EM_flush=1 in cycles 0-3, MDU_DONE with all enables 1 in cycle 4, IDLE in cycle 5.
REQ-029 Divide plus mem_wait: start at cycle 0, mem_wait=1 in cycles 10-40 -> cnt still reaches MDU_DONE; DONE holds until cycle 41; all enables 0 in cycles 10-40.
REQ-030 Reset mid-divide: rst=1 at cycle 5 of DIV -> state IDLE, mdu_busy=0, all enables 1 in cycle 6.
REQ-031 Jump vs load-use: id_jump_taken=1 with load_use=1 -> IR_flush=0, stall; next cycle jump alone -> IR_flush=1.
